// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and a
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UART_BAUD  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_err,
    output logic                        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             r_sync1, r_sync2, r_prev;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_push, w_push_nxt;
    logic             w_ferr_set;
    logic             w_fall;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_frame_err, r_overrun;
    logic             w_pop, w_push_ok, w_ovr_set;

    assign w_fall = !r_sync2 && r_prev;

    // Line synchronizer plus edge history; presets keep an idle-high line from looking like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_push    <= w_push_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push_nxt    = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_W'(HALF_BIT - 1)) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_sync2, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_push_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (r_sync2) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pop is evaluated first, so a push into a full FIFO succeeds when the head leaves together.
    assign w_pop     = (r_count != '0) && rx_ready;
    assign w_push_ok = r_push && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
    assign w_ovr_set = r_push && !w_push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)    r_overrun   <= 1'b1;
            else if (clr_err) r_overrun   <= 1'b0;
        end
    end

    assign rx_data    = r_mem[r_rd_ptr];
    assign rx_valid   = (r_count != '0);
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// frames compared against a queue-based model of the receive path.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 10;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic       m_ferr;
    logic       m_ovr;

    uart_rx_fifo #(
        .CLK_FREQ  (1_000_000),
        .UART_BAUD (100_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: a completed frame enters the FIFO unless it is full.
    task automatic model_push(input logic [7:0] b);
        if (q.size() < int'(DEPTH)) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), q.size());
        check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, "_data"}, 32'(rx_data), 32'(q[0]));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(rx_valid), 1);
            check("drain_data", 32'(rx_data), 32'(q[0]));
            rx_ready = 1'b1;
            @(negedge clk);
            void'(q.pop_front());
        end
        rx_ready = 1'b0;
        check("drain_after_valid", 32'(rx_valid), 32'(q.size() != 0));
        check("drain_after_count", 32'(fifo_count), q.size());
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        logic       busy_seen;
        logic [7:0] b;
        int         kind;

        rst      = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data), 0);
        check_state("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single frame, exact push latency
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (98) @(negedge clk);
                check("t1_valid_before", 32'(rx_valid), 0);
                @(negedge clk);
                check("t1_valid_edge", 32'(rx_valid), 1);
                check("t1_data_edge", 32'(rx_data), 32'hA5);
            end
        join
        model_push(8'hA5);
        check_state("t1");
        drain(1);

        // 2: start-bit glitch
        busy_seen = 1'b0;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check("t2_busy_pulse", 32'(busy_seen), 1);
        check_state("t2");

        // 3: bad stop bit with break, then a clean frame
        send_byte(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("t3_busy_break", 32'(busy), 1);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        m_ferr = 1'b1;
        check_state("t3_err");
        send_byte(8'h81, 1'b1);
        model_push(8'h81);
        check_state("t3_frame");
        pulse_clr();
        check_state("t3_clr");
        drain(1);

        // 4: six back-to-back frames overflow the FIFO
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i), 1'b1);
            model_push(8'(i));
        end
        check_state("t4_full");
        drain(4);
        check_state("t4_drained");
        pulse_clr();
        check_state("t4_clr");

        // 5: push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1);
            model_push(b);
        end
        check_state("t5_full");
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (98) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        void'(q.pop_front());
        model_push(8'h55);
        check_state("t5_after");
        check("t5_last", 32'(q[3]), 32'h55);
        drain(4);

        // 7: randomized traffic against the queue model
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 7));
            b    = 8'($urandom);
            if (kind == 0) begin
                uart_rx = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                uart_rx = 1'b1;
                repeat (15) @(negedge clk);
            end else if (kind == 1) begin
                send_byte(b, 1'b0);
                uart_rx = 1'b1;
                repeat (4) @(negedge clk);
                m_ferr = 1'b1;
            end else begin
                send_byte(b, 1'b1);
                model_push(b);
            end
            check_state("rnd");
            if ($urandom_range(0, 3) == 0) drain(q.size());
            if ($urandom_range(0, 4) == 0) begin
                pulse_clr();
                check_state("rnd_clr");
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        // 6: reset mid-DATA abandons the frame
        send_byte(8'h77, 1'b1);
        model_push(8'h77);
        send_byte(8'h00, 1'b0);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        m_ferr = 1'b1;
        check_state("t6_pre");
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t6_busy_mid", 32'(busy), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check("t6_data_rst", 32'(rx_data), 0);
        check_state("t6_rst");
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check_state("t6_idle");
        send_byte(8'h12, 1'b1);
        model_push(8'h12);
        check_state("t6_frame");
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
